fetch_pc_unit: RTL and testbench

//  Instruction-fetch front end of the 16-bit pipeline: owns the PC, issues requests to instruction

---
 rtl/fetch_pc_unit_pkg.sv | 16 +
 rtl/fetch_pc_unit_if.sv | 25 ++
 rtl/fetch_pc_unit_if_id_reg.sv | 45 ++++
 rtl/fetch_pc_unit.sv | 127 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pc_unit_pkg;

    localparam int          CPU_DATA_W    = 16;
    localparam logic [15:0] CPU_RESET_PC  = 16'h0000;
    localparam logic [3:0]  CPU_HLT_OP    = 4'hF;
    localparam logic [15:0] CPU_NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2,
        HALT   = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/response channel between the fetch unit and imem.
// Handshake: imem_req stays high with a stable imem_addr until a one-cycle
// imem_valid strobe returns imem_rdata; at most one request is outstanding.
interface fetch_pc_unit_if #(
    parameter int DATA_W = 16
);
    logic              imem_req;
    logic [DATA_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/fetch_pc_unit_if_id_reg.sv
// IF/ID pipeline register: load, hold, flush, and NOP fill whenever the entry is not live.
module fetch_pc_unit_if_id_reg #(
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [DATA_W-1:0] pc_plus2_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] instr_o,
    output logic [DATA_W-1:0] pc_plus2_o
);

    logic              valid_q;
    logic [DATA_W-1:0] instr_q;
    logic [DATA_W-1:0] pc_plus2_q;

    // Priority: flush kills, then a new load, then hold keeps, else a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_plus2_q <= '0;
        end else if (flush_i) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
        end else if (load_i) begin
            valid_q    <= 1'b1;
            instr_q    <= instr_i;
            pc_plus2_q <= pc_plus2_i;
        end else if (!hold_i) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
        end
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_plus2_o = pc_plus2_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch front end: PC register, fetch FSM, hold buffer and PC+2 adder feeding the IF/ID register.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int                DATA_W    = CPU_DATA_W,
    parameter logic [DATA_W-1:0] RESET_PC  = CPU_RESET_PC,
    parameter logic [3:0]        HLT_OP    = CPU_HLT_OP,
    parameter logic [DATA_W-1:0] NOP_INSTR = CPU_NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [DATA_W-1:0]      branch_target,
    fetch_pc_unit_if.master        imem,
    output logic                   if_id_valid,
    output logic [DATA_W-1:0]      if_id_instr,
    output logic [DATA_W-1:0]      if_id_pc_plus2,
    output logic                   halted,
    output fetch_state_t           dbg_state
);

    fetch_state_t      state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              started_q;
    logic [DATA_W-1:0] pc_plus2;
    logic              req;
    logic              load_en;
    logic [DATA_W-1:0] load_instr;
    logic              id_hold;

    assign pc_plus2 = pc_q + DATA_W'(2);

    // started_q keeps the first request off until the cycle after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            buf_q     <= NOP_INSTR;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            buf_q     <= buf_d;
            started_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        if (flush) begin
            pc_d = branch_target;
            // A response still owed by memory must be swallowed before refetching.
            if ((req || state_q == SQUASH) && !imem.imem_valid) begin
                state_d = SQUASH;
            end else begin
                state_d = FETCH;
            end
        end else if (load_en) begin
            pc_d    = pc_plus2;
            state_d = (load_instr[DATA_W-1 -: 4] == HLT_OP) ? HALT : FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (req && imem.imem_valid) begin
                        buf_d   = imem.imem_rdata;
                        state_d = HOLD;
                    end
                end
                SQUASH: begin
                    if (imem.imem_valid) begin
                        state_d = FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req        = started_q && (state_q == FETCH);
        load_en    = 1'b0;
        load_instr = imem.imem_rdata;
        id_hold    = stall || (state_q == HALT);
        if (!flush) begin
            case (state_q)
                FETCH: begin
                    if (req && imem.imem_valid && (!stall || !if_id_valid)) begin
                        load_en = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        load_en    = 1'b1;
                        load_instr = buf_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;
    assign halted         = (state_q == HALT);
    assign dbg_state      = state_q;

    fetch_pc_unit_if_id_reg #(
        .DATA_W    (DATA_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_en),
        .hold_i     (id_hold),
        .flush_i    (flush),
        .instr_i    (load_instr),
        .pc_plus2_i (pc_plus2),
        .valid_o    (if_id_valid),
        .instr_o    (if_id_instr),
        .pc_plus2_o (if_id_pc_plus2)
    );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: inputs change and outputs are checked on the falling edge.
module tb_fetch_pc_unit;
    import fetch_pc_unit_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall;
    logic         flush;
    logic [15:0]  branch_target;
    logic         if_id_valid;
    logic [15:0]  if_id_instr;
    logic [15:0]  if_id_pc_plus2;
    logic         halted;
    fetch_state_t dbg_state;

    int n_pass  = 0;
    int n_total = 0;
    int req_seen;

    fetch_pc_unit_if #(.DATA_W(16)) mem_if ();

    fetch_pc_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .branch_target  (branch_target),
        .imem           (mem_if),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus2 (if_id_pc_plus2),
        .halted         (halted),
        .dbg_state      (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic mem(input logic v, input logic [15:0] d);
        mem_if.imem_valid = v;
        mem_if.imem_rdata = d;
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [15:0] ins,
                            input logic [15:0] p2);
        chk({tag, "_valid"}, 32'(if_id_valid), 32'(v));
        chk({tag, "_instr"}, 32'(if_id_instr), 32'(ins));
        chk({tag, "_pcp2"}, 32'(if_id_pc_plus2), 32'(p2));
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [15:0] a);
        chk({tag, "_req"}, 32'(mem_if.imem_req), 32'(r));
        if (r) chk({tag, "_addr"}, 32'(mem_if.imem_addr), 32'(a));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = 16'h0000;
        mem(1'b0, 16'h0000);
        tick(); tick();

        // Reset state
        chk_req("rst", 1'b0, 16'h0000);
        chk_ifid("rst", 1'b0, 16'h0000, 16'h0000);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(FETCH));
        rst = 1'b0;
        tick();
        chk_req("first_req", 1'b1, 16'h0000);

        // 1-cycle memory, back-to-back fetches
        mem(1'b1, 16'h1111); tick();
        chk_ifid("b2b0", 1'b1, 16'h1111, 16'h0002);
        chk_req("b2b0", 1'b1, 16'h0002);
        mem(1'b1, 16'h2222); tick();
        chk_ifid("b2b1", 1'b1, 16'h2222, 16'h0004);
        chk_req("b2b1", 1'b1, 16'h0004);
        mem(1'b1, 16'h3333); tick();
        chk_ifid("b2b2", 1'b1, 16'h3333, 16'h0006);
        chk_req("b2b2", 1'b1, 16'h0006);

        // 3-cycle latency: request held, bubble in IF/ID meanwhile
        mem(1'b0, 16'h0000); tick();
        chk_req("lat3_c2", 1'b1, 16'h0006);
        chk_ifid("lat3_bub", 1'b0, 16'h0000, 16'h0006);
        tick();
        chk_req("lat3_c3", 1'b1, 16'h0006);
        mem(1'b1, 16'h4444); tick();
        chk_ifid("lat3_load", 1'b1, 16'h4444, 16'h0008);
        chk_req("lat3_next", 1'b1, 16'h0008);
        mem(1'b0, 16'h0000); tick();
        chk("lat3_bub2", 32'(if_id_valid), 32'd0);

        // Stall with live IF/ID: response parked in the hold buffer
        mem(1'b1, 16'h5555); tick();
        chk_ifid("stl_pre", 1'b1, 16'h5555, 16'h000A);
        stall = 1'b1; mem(1'b1, 16'h6666); tick();
        chk("stl_state", 32'(dbg_state), 32'(HOLD));
        chk_req("stl", 1'b0, 16'h0000);
        chk_ifid("stl_keep", 1'b1, 16'h5555, 16'h000A);
        mem(1'b0, 16'h0000); tick();
        chk("stl_state2", 32'(dbg_state), 32'(HOLD));
        chk_ifid("stl_keep2", 1'b1, 16'h5555, 16'h000A);
        stall = 1'b0; tick();
        chk_ifid("stl_rel", 1'b1, 16'h6666, 16'h000C);
        chk("stl_rel_state", 32'(dbg_state), 32'(FETCH));
        chk_req("stl_rel", 1'b1, 16'h000C);

        // Flush with a request outstanding: stale response dropped
        tick();
        flush = 1'b1; branch_target = 16'h0100; tick();
        flush = 1'b0;
        chk("fl_state", 32'(dbg_state), 32'(SQUASH));
        chk_req("fl_sq", 1'b0, 16'h0000);
        chk("fl_valid", 32'(if_id_valid), 32'd0);
        mem(1'b1, 16'h7777); tick();
        chk_ifid("fl_drop", 1'b0, 16'h0000, 16'h000C);
        chk_req("fl_new", 1'b1, 16'h0100);
        // Flush and response in the same cycle
        flush = 1'b1; branch_target = 16'h0200; mem(1'b1, 16'h8888); tick();
        flush = 1'b0; mem(1'b0, 16'h0000);
        chk("flv_valid", 32'(if_id_valid), 32'd0);
        chk("flv_state", 32'(dbg_state), 32'(FETCH));
        chk_req("flv", 1'b1, 16'h0200);

        // HLT fetched: fetch stops until a flush
        mem(1'b1, 16'hF000); tick();
        mem(1'b0, 16'h0000);
        chk("hlt_halted", 32'(halted), 32'd1);
        chk_ifid("hlt", 1'b1, 16'hF000, 16'h0202);
        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            stall = 1'(($urandom_range(0, 1)));
            tick();
            if (mem_if.imem_req) req_seen++;
        end
        stall = 1'b0;
        chk("hlt_no_req", 32'(req_seen), 32'd0);
        chk_ifid("hlt_keep", 1'b1, 16'hF000, 16'h0202);
        flush = 1'b1; branch_target = 16'h0040; tick();
        flush = 1'b0;
        chk("hlt_clr", 32'(halted), 32'd0);
        chk("hlt_clr_valid", 32'(if_id_valid), 32'd0);
        chk_req("hlt_restart", 1'b1, 16'h0040);

        // PC wrap at FFFE
        flush = 1'b1; branch_target = 16'hFFFE; mem(1'b1, 16'h9999); tick();
        flush = 1'b0;
        chk_req("wrap_pre", 1'b1, 16'hFFFE);
        mem(1'b1, 16'h1234); tick();
        chk_ifid("wrap", 1'b1, 16'h1234, 16'h0000);
        chk_req("wrap", 1'b1, 16'h0000);
        mem(1'b1, 16'h5678); tick();
        chk_ifid("wrap2", 1'b1, 16'h5678, 16'h0002);
        mem(1'b0, 16'h0000); tick();
        chk_req("wait", 1'b1, 16'h0002);

        // Asynchronous reset in the middle of a wait
        #2 rst = 1'b1;
        #1;
        chk_req("arst", 1'b0, 16'h0000);
        chk("arst_addr", 32'(mem_if.imem_addr), 32'h0000);
        chk_ifid("arst", 1'b0, 16'h0000, 16'h0000);
        chk("arst_halted", 32'(halted), 32'd0);
        chk("arst_state", 32'(dbg_state), 32'(FETCH));
        tick();
        rst = 1'b0; tick();
        chk_req("arst_restart", 1'b1, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
